// File: rtl/load_dcache_arbiter.sv
// Round-robin arbiter sharing one data-cache read port among NUM_LD load units.
// It routes hit data, and later miss-refill broadcasts, back to the load unit that owns each request.
module load_dcache_arbiter #(
  parameter int NUM_LD = 2,
  parameter int XLEN   = 32,
  parameter int TAG_W  = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   squash,
  input  logic [NUM_LD-1:0]      ld_req_en,
  input  logic [NUM_LD*XLEN-1:0] ld_req_addr,
  output logic [NUM_LD-1:0]      ld_is_hit,
  output logic [NUM_LD-1:0]      ld_bcast_en,
  output logic [NUM_LD*XLEN-1:0] ld_data,
  output logic                   dc_req_valid,
  output logic [XLEN-1:0]        dc_req_addr,
  input  logic                   dc_req_ready,
  input  logic                   dc_hit,
  input  logic [XLEN-1:0]        dc_data,
  input  logic [TAG_W-1:0]       dc_miss_tag,
  input  logic                   dc_bcast_en,
  input  logic [TAG_W-1:0]       dc_bcast_tag,
  input  logic [XLEN-1:0]        dc_bcast_data
);

  localparam int PTR_W = (NUM_LD > 2) ? 2 : 1;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] PEND      = 2'd1;
  localparam logic [1:0] WAIT_MISS = 2'd2;

  logic [1:0]       state_r [NUM_LD];
  logic [XLEN-1:0]  addr_r  [NUM_LD];
  logic [TAG_W-1:0] tag_r   [NUM_LD];
  logic [PTR_W-1:0] rr_ptr_r;

  logic [NUM_LD-1:0] bypass_s;
  logic [NUM_LD-1:0] cand_s;
  logic [NUM_LD-1:0] bmatch_s;
  logic [PTR_W-1:0]  grant_s;
  logic [PTR_W-1:0]  rr_next_s;
  logic [XLEN-1:0]   sel_addr_s;
  logic              accept_s;

  function automatic int wrap_idx(input int base, input int k);
    return (base + k) % NUM_LD;
  endfunction

  // Candidate collection, round-robin grant and the request to the dcache.
  always_comb begin
    bypass_s   = '0;
    cand_s     = '0;
    grant_s    = '0;
    sel_addr_s = '0;
    for (int i = 0; i < NUM_LD; i++) begin
      bypass_s[i] = (state_r[i] == IDLE) && ld_req_en[i];
      cand_s[i]   = reset && !squash && ((state_r[i] == PEND) || bypass_s[i]);
    end
    // Scanning from the farthest position down leaves the nearest candidate at or after rr_ptr.
    for (int k = NUM_LD - 1; k >= 0; k--) begin
      grant_s = cand_s[PTR_W'(wrap_idx(int'(rr_ptr_r), k))] ?
                PTR_W'(wrap_idx(int'(rr_ptr_r), k)) : grant_s;
    end
    for (int i = 0; i < NUM_LD; i++) begin
      if (grant_s == PTR_W'(i)) begin
        sel_addr_s = bypass_s[i] ? ld_req_addr[i*XLEN +: XLEN] : addr_r[i];
      end else begin
        sel_addr_s = sel_addr_s;
      end
    end
    dc_req_valid = |cand_s;
    dc_req_addr  = dc_req_valid ? {sel_addr_s[XLEN-1:2], 2'b00} : '0;
    accept_s     = dc_req_valid && dc_req_ready;
    rr_next_s    = (grant_s == PTR_W'(NUM_LD - 1)) ? '0 : grant_s + PTR_W'(1);
  end

  // Per-unit responses: same-cycle hit data or a matching refill broadcast.
  always_comb begin
    ld_is_hit   = '0;
    ld_bcast_en = '0;
    ld_data     = '0;
    bmatch_s    = '0;
    for (int i = 0; i < NUM_LD; i++) begin
      bmatch_s[i]    = reset && !squash && dc_bcast_en &&
                       (state_r[i] == WAIT_MISS) && (tag_r[i] == dc_bcast_tag);
      ld_is_hit[i]   = accept_s && dc_hit && (grant_s == PTR_W'(i));
      ld_bcast_en[i] = bmatch_s[i];
      if (ld_is_hit[i]) begin
        ld_data[i*XLEN +: XLEN] = dc_data;
      end else if (bmatch_s[i]) begin
        ld_data[i*XLEN +: XLEN] = dc_bcast_data;
      end else begin
        ld_data[i*XLEN +: XLEN] = '0;
      end
    end
  end

  // Per-unit state, latched address and miss tag, plus the round-robin pointer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr_r <= '0;
      for (int i = 0; i < NUM_LD; i++) begin
        state_r[i] <= IDLE;
        addr_r[i]  <= '0;
        tag_r[i]   <= '0;
      end
    end else if (squash) begin
      for (int i = 0; i < NUM_LD; i++) begin
        state_r[i] <= IDLE;
      end
    end else begin
      if (accept_s) begin
        rr_ptr_r <= rr_next_s;
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end
      for (int i = 0; i < NUM_LD; i++) begin
        if (bmatch_s[i]) begin
          state_r[i] <= IDLE;
        end else if (accept_s && (grant_s == PTR_W'(i))) begin
          state_r[i] <= dc_hit ? IDLE : WAIT_MISS;
          tag_r[i]   <= dc_miss_tag;
        end else if (bypass_s[i]) begin
          state_r[i] <= PEND;
          addr_r[i]  <= ld_req_addr[i*XLEN +: XLEN];
        end else begin
          state_r[i] <= state_r[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_load_dcache_arbiter.sv
// Directed bench for load_dcache_arbiter with two load units: hits, contention, misses,
// merged refills, backpressure, squash and asynchronous reset.
module tb_load_dcache_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        squash;
  logic [1:0]  ld_req_en;
  logic [63:0] ld_req_addr;
  logic [1:0]  ld_is_hit;
  logic [1:0]  ld_bcast_en;
  logic [63:0] ld_data;
  logic        dc_req_valid;
  logic [31:0] dc_req_addr;
  logic        dc_req_ready;
  logic        dc_hit;
  logic [31:0] dc_data;
  logic [1:0]  dc_miss_tag;
  logic        dc_bcast_en;
  logic [1:0]  dc_bcast_tag;
  logic [31:0] dc_bcast_data;

  int vectors = 0;
  int miscompares = 0;

  load_dcache_arbiter #(.NUM_LD(2), .XLEN(32), .TAG_W(2)) dut (
    .clock(clock), .reset(reset), .squash(squash),
    .ld_req_en(ld_req_en), .ld_req_addr(ld_req_addr),
    .ld_is_hit(ld_is_hit), .ld_bcast_en(ld_bcast_en), .ld_data(ld_data),
    .dc_req_valid(dc_req_valid), .dc_req_addr(dc_req_addr),
    .dc_req_ready(dc_req_ready), .dc_hit(dc_hit), .dc_data(dc_data),
    .dc_miss_tag(dc_miss_tag), .dc_bcast_en(dc_bcast_en),
    .dc_bcast_tag(dc_bcast_tag), .dc_bcast_data(dc_bcast_data)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] en, input logic [31:0] a0, input logic [31:0] a1,
                       input logic rdy, input logic hit, input logic [31:0] data,
                       input logic [1:0] mtag, input logic ben, input logic [1:0] btag,
                       input logic [31:0] bdata, input logic sq);
    ld_req_en     = en;
    ld_req_addr   = {a1, a0};
    dc_req_ready  = rdy;
    dc_hit        = hit;
    dc_data       = data;
    dc_miss_tag   = mtag;
    dc_bcast_en   = ben;
    dc_bcast_tag  = btag;
    dc_bcast_data = bdata;
    squash        = sq;
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are checked 3 units later.
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    drive(2'b01, 32'h100, 32'h0, 1'b1, 1'b1, 32'hDEADBEEF, 2'd0, 1'b1, 2'd0, 32'h1, 1'b0);
    #3;
    chk("reset_valid", {63'd0, dc_req_valid}, 64'd0);
    chk("reset_hit", {62'd0, ld_is_hit}, 64'd0);
    chk("reset_data", ld_data, 64'd0);
    next_cycle();
    reset = 1'b1;

    // Single uncontended hit on FU0.
    drive(2'b01, 32'h100, 32'h0, 1'b1, 1'b1, 32'hDEADBEEF, 2'd0, 1'b0, 2'd0, 32'h0, 1'b0);
    #3;
    chk("hit_addr", {32'd0, dc_req_addr}, 64'h100);
    chk("hit_en", {62'd0, ld_is_hit}, 64'h1);
    chk("hit_data", ld_data, 64'h00000000_DEADBEEF);
    next_cycle();
    drive(2'b00, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0, 2'd0, 1'b0, 2'd0, 32'h0, 1'b0);
    #3;
    chk("hit_fu0_idle", {63'd0, dc_req_valid}, 64'd0);
    next_cycle();

    // FU1 hit with a misaligned address; rr_ptr returns to 0.
    drive(2'b10, 32'h0, 32'h107, 1'b1, 1'b1, 32'h11112222, 2'd0, 1'b0, 2'd0, 32'h0, 1'b0);
    #3;
    chk("align_addr", {32'd0, dc_req_addr}, 64'h104);
    chk("align_data", ld_data, 64'h11112222_00000000);
    next_cycle();

    // Contention: FU0 wins, FU1 follows from PEND.
    drive(2'b11, 32'h200, 32'h300, 1'b1, 1'b1, 32'hA0, 2'd0, 1'b0, 2'd0, 32'h0, 1'b0);
    #3;
    chk("cont0_addr", {32'd0, dc_req_addr}, 64'h200);
    chk("cont0_hit", {62'd0, ld_is_hit}, 64'h1);
    next_cycle();
    drive(2'b00, 32'h0, 32'h0, 1'b1, 1'b1, 32'hB0, 2'd0, 1'b0, 2'd0, 32'h0, 1'b0);
    #3;
    chk("cont1_addr", {32'd0, dc_req_addr}, 64'h300);
    chk("cont1_hit", {62'd0, ld_is_hit}, 64'h2);
    chk("cont1_data", ld_data, 64'h000000B0_00000000);
    next_cycle();

    // Backpressure for three cycles, then both miss on tag 1.
    drive(2'b11, 32'h500, 32'h600, 1'b0, 1'b0, 32'h0, 2'd1, 1'b0, 2'd0, 32'h0, 1'b0);
    #3;
    chk("bp0_valid", {63'd0, dc_req_valid}, 64'd1);
    chk("bp0_addr", {32'd0, dc_req_addr}, 64'h500);
    chk("bp0_hit", {62'd0, ld_is_hit}, 64'd0);
    next_cycle();
    drive(2'b01, 32'h900, 32'h0, 1'b0, 1'b0, 32'h0, 2'd1, 1'b0, 2'd0, 32'h0, 1'b0);
    #3;
    chk("bp1_ignore_req", {32'd0, dc_req_addr}, 64'h500);
    next_cycle();
    drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 2'd1, 1'b0, 2'd0, 32'h0, 1'b0);
    #3;
    chk("bp2_valid", {63'd0, dc_req_valid}, 64'd1);
    next_cycle();
    drive(2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 2'd1, 1'b0, 2'd0, 32'h0, 1'b0);
    #3;
    chk("miss0_addr", {32'd0, dc_req_addr}, 64'h500);
    chk("miss0_out", {60'd0, ld_is_hit, ld_bcast_en}, 64'd0);
    next_cycle();
    drive(2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 2'd1, 1'b0, 2'd0, 32'h0, 1'b0);
    #3;
    chk("miss1_addr", {32'd0, dc_req_addr}, 64'h600);
    next_cycle();
    drive(2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 2'd0, 1'b1, 2'd1, 32'hCAFEF00D, 1'b0);
    #3;
    chk("merge_bcast", {62'd0, ld_bcast_en}, 64'h3);
    chk("merge_data", ld_data, 64'hCAFEF00D_CAFEF00D);
    next_cycle();

    // FU1 miss on tag 2, refilled five cycles later.
    drive(2'b10, 32'h0, 32'h400, 1'b1, 1'b0, 32'h0, 2'd2, 1'b0, 2'd0, 32'h0, 1'b0);
    #3;
    chk("refill_req", {32'd0, dc_req_addr}, 64'h400);
    chk("refill_noout", {60'd0, ld_is_hit, ld_bcast_en}, 64'd0);
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      drive(2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 2'd0, 1'b0, 2'd0, 32'h0, 1'b0);
    end
    next_cycle();
    drive(2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 2'd0, 1'b1, 2'd2, 32'h12345678, 1'b0);
    #3;
    chk("refill_bcast", {62'd0, ld_bcast_en}, 64'h2);
    chk("refill_data", ld_data, 64'h12345678_00000000);
    next_cycle();

    // Non-matching broadcast leaves FU0 waiting on tag 0.
    drive(2'b01, 32'h700, 32'h0, 1'b1, 1'b0, 32'h0, 2'd0, 1'b0, 2'd0, 32'h0, 1'b0);
    next_cycle();
    drive(2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 2'd0, 1'b1, 2'd3, 32'h55, 1'b0);
    #3;
    chk("nomatch_bcast", {62'd0, ld_bcast_en}, 64'd0);
    next_cycle();
    drive(2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 2'd0, 1'b1, 2'd0, 32'h0BAD0BAD, 1'b0);
    #3;
    chk("still_wait_bcast", {62'd0, ld_bcast_en}, 64'h1);
    chk("still_wait_data", ld_data, 64'h00000000_0BAD0BAD);
    next_cycle();

    // Squash with FU0 in WAIT_MISS(tag0) and FU1 in PEND; rr_ptr stays at 1.
    drive(2'b01, 32'h710, 32'h0, 1'b1, 1'b0, 32'h0, 2'd0, 1'b0, 2'd0, 32'h0, 1'b0);
    next_cycle();
    drive(2'b10, 32'h0, 32'h800, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 2'd0, 32'h0, 1'b0);
    #3;
    chk("pre_squash_addr", {32'd0, dc_req_addr}, 64'h800);
    next_cycle();
    drive(2'b01, 32'h880, 32'h0, 1'b1, 1'b1, 32'h77, 2'd0, 1'b1, 2'd0, 32'h66, 1'b1);
    #3;
    chk("squash_valid", {63'd0, dc_req_valid}, 64'd0);
    chk("squash_out", {60'd0, ld_is_hit, ld_bcast_en}, 64'd0);
    chk("squash_data", ld_data, 64'd0);
    next_cycle();
    drive(2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 2'd0, 1'b0, 2'd0, 32'h0, 1'b0);
    #3;
    chk("post_squash_valid", {63'd0, dc_req_valid}, 64'd0);
    next_cycle();
    drive(2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 2'd0, 1'b1, 2'd0, 32'h99, 1'b0);
    #3;
    chk("post_squash_bcast", {62'd0, ld_bcast_en}, 64'd0);
    next_cycle();
    drive(2'b11, 32'hA00, 32'hB00, 1'b1, 1'b1, 32'hC1, 2'd0, 1'b0, 2'd0, 32'h0, 1'b0);
    #3;
    chk("rr_kept_addr", {32'd0, dc_req_addr}, 64'hB00);
    chk("rr_kept_hit", {62'd0, ld_is_hit}, 64'h2);
    next_cycle();

    // FU0 (PEND) misses on tag 3, then asynchronous reset mid-cycle.
    drive(2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 2'd3, 1'b0, 2'd0, 32'h0, 1'b0);
    #3;
    chk("pend_fu0_addr", {32'd0, dc_req_addr}, 64'hA00);
    next_cycle();
    drive(2'b10, 32'h0, 32'hC00, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 2'd0, 32'h0, 1'b0);
    #2;
    chk("pre_reset_valid", {63'd0, dc_req_valid}, 64'd1);
    reset = 1'b0;
    dc_bcast_en  = 1'b1;
    dc_bcast_tag = 2'd3;
    #1;
    chk("async_reset_valid", {63'd0, dc_req_valid}, 64'd0);
    chk("async_reset_addr", {32'd0, dc_req_addr}, 64'd0);
    chk("async_reset_bcast", {62'd0, ld_bcast_en}, 64'd0);
    next_cycle();
    reset = 1'b1;
    drive(2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 2'd0, 1'b1, 2'd3, 32'hEE, 1'b0);
    #3;
    chk("tag_discarded", {62'd0, ld_bcast_en}, 64'd0);
    chk("pend_discarded", {63'd0, dc_req_valid}, 64'd0);
    next_cycle();
    drive(2'b11, 32'hD00, 32'hE00, 1'b1, 1'b1, 32'hF0, 2'd0, 1'b0, 2'd0, 32'h0, 1'b0);
    #3;
    chk("rr_reset_addr", {32'd0, dc_req_addr}, 64'hD00);
    next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/load_dcache_arbiter.md
Name: load_dcache_arbiter

Overview:
- Shares the single data-cache read port among NUM_LD load functional units.
- Each load FU raises a one-cycle cache_read_EN pulse with a word-aligned addr and then waits until it sees either is_hit or broadcast_en.
- The arbiter latches each request, grants one request per cycle round-robin, and routes hit data, miss tags and later refill broadcasts back to the owning FU.
- Sits between the load FUs and the dcache/MSHR block.

Parameters:
NUM_LD, 2, number of load FUs sharing the port (2..4)
XLEN, 32, address/data width
TAG_W, 2, MSHR tag width returned by dcache on miss

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
squash  in  1  pipeline flush; drops all pending and in-flight requests
ld_req_en  in  NUM_LD  per-FU one-cycle read request pulse (cache_read_EN)
ld_req_addr  in  NUM_LD*XLEN  per-FU word-aligned address, valid when ld_req_en
ld_is_hit  out  NUM_LD  per-FU hit indication, one cycle
ld_bcast_en  out  NUM_LD  per-FU miss-refill delivery, one cycle
ld_data  out  NUM_LD*XLEN  per-FU data, valid with ld_is_hit or ld_bcast_en, else 0
dc_req_valid  out  1  request to dcache this cycle
dc_req_addr  out  XLEN  granted address
dc_req_ready  in  1  dcache can accept (MSHR not full); combinational in same cycle
dc_hit  in  1  same-cycle hit for accepted request
dc_data  in  XLEN  hit data
dc_miss_tag  in  TAG_W  MSHR tag assigned when accepted and !dc_hit
dc_bcast_en  in  1  refill broadcast
dc_bcast_tag  in  TAG_W  tag of refill
dc_bcast_data  in  XLEN  refill word for that tag

Behaviour:
- Per-FU state machine: IDLE, PEND (latched, not yet accepted), WAIT_MISS (accepted, holding a miss tag).
- Per-FU registers: addr, tag.
- One round-robin pointer rr_ptr.

Reset (async, reset=0):
- All FUs go to IDLE.
- rr_ptr=0.
- All outputs 0.
- Reset asserted mid-miss discards the tag; any later broadcast for it is ignored.

Candidates and grant:
- Candidate set = FUs in PEND, plus FUs in IDLE with ld_req_en=1 (bypass: a new request can be granted in its arrival cycle).
- Grant = first candidate at or after rr_ptr, modulo NUM_LD.
- dc_req_valid = any candidate.
- dc_req_addr = granted address (ld_req_addr on bypass, latched addr otherwise).
- Accepted = dc_req_valid and dc_req_ready.

Accepted and dc_hit:
- ld_is_hit[g]=1 and ld_data[g]=dc_data in the same cycle.
- FU g goes to IDLE.

Accepted and !dc_hit:
- FU g goes to WAIT_MISS with tag=dc_miss_tag.
- No FU output is asserted.

Not accepted (dc_req_ready=0), or candidate not granted:
- A bypass request is latched and the FU goes to PEND.
- A PEND FU stays in PEND.
- rr_ptr is unchanged.

Round-robin update:
- On every accept, rr_ptr <= g+1 (wrap to 0 after NUM_LD-1).

Broadcast:
- When dc_bcast_en=1, every FU in WAIT_MISS with tag==dc_bcast_tag gets ld_bcast_en=1 and ld_data=dc_bcast_data that cycle, then goes to IDLE.
- Multiple FUs may match the same tag (merged miss).
- A broadcast and a grant for different FUs in the same cycle are both honoured.
- A FU's own hit and a broadcast cannot coincide, because each FU has at most one outstanding request.
- ld_is_hit and ld_bcast_en are never both high for the same FU.

Protocol errors:
- ld_req_en while the FU is not IDLE is ignored; the state is unchanged.
- ld_req_addr[1:0] is ignored; the address is treated as word-aligned.

Squash:
- All FUs go to IDLE next cycle.
- Requests and broadcasts in the squash cycle produce no ld_* outputs.
- dc_req_valid=0 in that cycle.
- Outstanding MSHR tags are forgotten.
- rr_ptr is kept.

Latency:
- Hit with no contention: 0 cycles (same cycle as ld_req_en).
- Each lost arbitration adds 1 cycle.

Test Plan:
- Single hit: FU0 ld_req_en with addr=0x100, dc_req_ready=1, dc_hit=1, dc_data=0xDEADBEEF -> same cycle dc_req_addr=0x100, ld_is_hit=2'b01, ld_data[0]=0xDEADBEEF; FU0 back in IDLE.
- Contention: both FUs request (0x200, 0x300) with rr_ptr=0, all hits -> cycle0 grant FU0 (0x200); cycle1 grant FU1 (0x300) from PEND; rr_ptr ends at 0.
- Miss/refill: FU1 requests 0x400, dc_hit=0, dc_miss_tag=2 -> no output; 5 cycles later dc_bcast_en=1, tag=2, data=0x12345678 -> ld_bcast_en=2'b10, ld_data[1]=0x12345678.
- Merged miss and backpressure: FU0 and FU1 both miss with tag 1, while dc_req_ready=0 for 3 cycles beforehand -> dc_req_valid is held with no grant progress; a single broadcast with tag 1 raises ld_bcast_en=2'b11 in the same cycle.
- Broadcast with non-matching tag 3 while FU0 waits on tag 0 -> no ld_bcast_en; FU0 stays in WAIT_MISS.
- Squash and reset: FU0 in WAIT_MISS(tag0) and FU1 in PEND, assert squash -> both IDLE next cycle; a later broadcast for tag 0 produces no output. Repeat with reset=0 asserted asynchronously mid-cycle -> outputs 0 immediately.
